rvecc_pipe: RTL
===============

# rvecc_pipe

Parametrised, pipelined SECDED check-and-correct block with error accounting. It is the next-generation replacement for the fixed 32-bit combinational ECC decoder, and it sits between SRAM read data and the consumer (DCCM, ICCM, I$ data path). It supports any data width from 8 to 64 bits. It corrects single-bit errors and flags double errors in a registered two-stage pipeline. It also keeps saturating SEC/DED counters and a first-error log for firmware scrubbing.

## Interface
Parameters:
- DATA_WIDTH, 32: protected data bits, 8..64.
- ADDR_WIDTH, 32: width of the tag carried alongside each word for logging.
- CNT_WIDTH, 16: width of each error counter.
- Derived, not overridable: K = smallest integer with 2^K >= DATA_WIDTH+K+1. ECC_WIDTH = K+1. For DATA_WIDTH=32: K=6, ECC_WIDTH=7.

Ports (reset is asynchronous and active-high):
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  word present this cycle.
- in_data  in  DATA_WIDTH  raw read data.
- in_ecc  in  ECC_WIDTH  stored check bits.
- in_addr  in  ADDR_WIDTH  address/tag, used only for the log.
- sed_ded  in  1  detect-only mode: no correction, overall parity ignored.
- out_valid  out  1  in_valid delayed by 2.
- out_data  out  DATA_WIDTH  corrected data.
- out_ecc  out  ECC_WIDTH  corrected check bits, for write-back scrub.
- out_sec  out  1  single error corrected (qualified by out_valid).
- out_ded  out  1  uncorrectable error (qualified by out_valid).
- sec_count  out  CNT_WIDTH  saturating SEC count.
- ded_count  out  CNT_WIDTH  saturating DED count.
- cnt_clear  in  1  synchronous clear of both counters.
- log_valid  out  1  the log holds an error.
- log_addr  out  ADDR_WIDTH  address of the logged error.
- log_syndrome  out  ECC_WIDTH  raw syndrome of the logged error.
- log_ded  out  1  logged error was a DED.
- log_clear  in  1  synchronous log release.

## Operation
- Codeword layout: positions 1..DATA_WIDTH+K.
  - Check bit i sits at position 2^i.
  - Data bits fill the remaining positions in ascending order, data bit 0 at position 3.
  - ecc[K] is overall parity over data and ecc[K-1:0].
  - For 32 bits this layout is bit-identical to the existing encoder.
- Stage 1 computes the syndrome:
  - s[K-1:0] = recomputed Hamming bits XOR in_ecc[K-1:0].
  - p = XOR of all data and all ECC bits, forced to 0 when sed_ded=1.
  - Stage 1 registers s, p, data, ecc, addr and sed_ded.
- Stage 2 classifies and registers the result:
  - s==0 and p==0: clean.
  - p==1 and s==0: SEC; flip ecc[K].
  - p==1 and 1<=s<=DATA_WIDTH+K: SEC; flip codeword bit s.
  - p==1 and s>DATA_WIDTH+K: DED (new: an invalid position is never treated as correctable).
  - p==0 and s!=0: DED; data passes through uncorrected.
  - sed_ded=1: any nonzero s gives DED; no correction is applied.
- out_sec and out_ded are mutually exclusive and are 0 whenever out_valid=0.
- Counters:
  - Each counter increments on out_valid & out_sec (sec_count) or out_valid & out_ded (ded_count).
  - Counters saturate at all-ones.
  - If cnt_clear and an event occur in the same cycle, the counter's next value is 1, so the event is not lost.
- Log:
  - Captures the first error when log_valid=0.
  - A DED overwrites a held SEC log.
  - A held DED log is frozen until log_clear.
  - If log_clear and an error occur in the same cycle, the new error is captured and log_valid stays 1.

## Timing
- Latency is exactly 2 cycles, in to out. There is no backpressure; one word is accepted per cycle.
- Counters and log update on the edge that registers out_*, so they are visible the cycle after out_valid.
- Reset values: out_valid, out_sec, out_ded, log_valid and log_ded are 0; sec_count and ded_count are 0; out_data, out_ecc, log_addr and log_syndrome are 0.
- Pipeline valid bits clear on reset. Words in flight when rst asserts are dropped and never counted.

## Structure
- Package rvecc_pkg holds:
  - function ecc_k(dw) returning K;
  - function data_pos(dw, j) giving the codeword position of data bit j;
  - function ecc_encode(dw, data) for encoders and benches;
  - enum ecc_status_e {ECC_OK, ECC_SEC, ECC_DED}.
- Sub-module rvecc_syndrome: combinational, parametrised by DATA_WIDTH, produces s and p. It is shared with a future standalone encoder.

## Test plan
- DATA_WIDTH=32, data 0x0000_0000, ecc 0x00 -> out_valid after 2 cycles, out_data 0, no flags, counters 0.
- Same word with data bit 0 flipped (data 0x0000_0001) -> out_sec=1, out_data 0x0000_0000, log_syndrome 0x43, sec_count 1.
- Data bits 0 and 1 flipped -> out_ded=1, data passes through as 0x0000_0003, log_ded=1. A later SEC does not change the log until log_clear.
- DATA_WIDTH=8 (K=4), ecc[4] flipped only -> SEC with out_ecc corrected. A syndrome of 13 with p=1 (positions 1..12 are valid) -> DED.
- CNT_WIDTH=2, five consecutive SEC words -> sec_count 1,2,3,3,3. cnt_clear on the fifth word -> 1.
- rst asserted with 2 words in flight -> no out_valid after reset, counters 0, log_valid 0.

Source files
------------

// File: rtl/rvecc_pkg.sv
// Shared SECDED definitions: codeword geometry helpers, a reference
// encoder and the decode status type used by the ECC check pipeline.
package rvecc_pkg;

  localparam int MAX_DW = 64;
  localparam int MAX_EW = 8;

  typedef enum logic [1:0] {
    ECC_OK  = 2'd0,
    ECC_SEC = 2'd1,
    ECC_DED = 2'd2
  } ecc_status_e;

  // Smallest K with 2^K >= dw + K + 1.
  function automatic int ecc_k(input int dw);
    int k;
    k = 7;
    for (int i = 7; i >= 1; i--) begin
      if ((1 << i) >= dw + i + 1) k = i;
    end
    return k;
  endfunction

  // Codeword position of data bit j; data skips the power-of-two slots.
  function automatic int data_pos(input int dw, input int j);
    int pos;
    int cnt;
    int last;
    pos  = 0;
    cnt  = 0;
    last = dw + ecc_k(dw);
    for (int p = 3; p <= 127; p++) begin
      if (p <= last && (p & (p - 1)) != 0) begin
        if (cnt == j) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // Data bits covered by Hamming check bit i.
  function automatic logic [MAX_DW-1:0] ecc_mask(input int dw, input int i);
    logic [MAX_DW-1:0] m;
    m = '0;
    for (int j = 0; j < MAX_DW; j++) begin
      if (j < dw && ((data_pos(dw, j) >> i) & 1) != 0) m[j] = 1'b1;
    end
    return m;
  endfunction

  // Full check-bit vector for a dw-bit word; ecc[K] is overall parity.
  function automatic logic [MAX_EW-1:0] ecc_encode(input int dw, input logic [MAX_DW-1:0] data);
    logic [MAX_EW-1:0] e;
    logic              par;
    int                k;
    k   = ecc_k(dw);
    e   = '0;
    par = 1'b0;
    for (int i = 0; i < MAX_EW - 1; i++) begin
      if (i < k) e[i] = ^(data & ecc_mask(dw, i));
    end
    for (int j = 0; j < MAX_DW; j++) begin
      if (j < dw) par = par ^ data[j];
    end
    for (int i = 0; i < MAX_EW - 1; i++) begin
      if (i < k) par = par ^ e[i];
    end
    e[k] = par;
    return e;
  endfunction

endpackage

// File: rtl/rvecc_syndrome.sv
// Combinational Hamming syndrome and overall parity for one codeword.
// Kept standalone so an encoder can reuse the same check-bit trees.
module rvecc_syndrome import rvecc_pkg::*; #(
  parameter  int DATA_WIDTH = 32,
  localparam int K          = ecc_k(DATA_WIDTH),
  localparam int ECC_WIDTH  = K + 1
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ECC_WIDTH-1:0]  ecc,
  output logic [K-1:0]          syn,
  output logic                  parity
);

  for (genvar i = 0; i < K; i++) begin : g_syn
    localparam logic [MAX_DW-1:0] MASK = ecc_mask(DATA_WIDTH, i);
    assign syn[i] = ^(data & MASK[DATA_WIDTH-1:0]) ^ ecc[i];
  end

  assign parity = ^data ^ ^ecc;

endmodule

// File: rtl/rvecc_pipe.sv
// Two-stage SECDED check-and-correct pipeline with saturating error
// counters and a first-error log for firmware scrubbing.
module rvecc_pipe import rvecc_pkg::*; #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 32,
  parameter  int CNT_WIDTH  = 16,
  localparam int K          = ecc_k(DATA_WIDTH),
  localparam int ECC_WIDTH  = K + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ECC_WIDTH-1:0]  in_ecc,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  sed_ded,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ECC_WIDTH-1:0]  out_ecc,
  output logic                  out_sec,
  output logic                  out_ded,
  output logic [CNT_WIDTH-1:0]  sec_count,
  output logic [CNT_WIDTH-1:0]  ded_count,
  input  logic                  cnt_clear,
  output logic                  log_valid,
  output logic [ADDR_WIDTH-1:0] log_addr,
  output logic [ECC_WIDTH-1:0]  log_syndrome,
  output logic                  log_ded,
  input  logic                  log_clear
);

  localparam int NBITS = DATA_WIDTH + K;

  logic [K-1:0]            syn_c;
  logic                    par_c;

  logic                    s1_valid;
  logic [K-1:0]            s1_syn;
  logic                    s1_par;
  logic [DATA_WIDTH-1:0]   s1_data;
  logic [ECC_WIDTH-1:0]    s1_ecc;
  logic [ADDR_WIDTH-1:0]   s1_addr;
  logic                    s1_sed_ded;

  ecc_status_e             status;
  logic                    syn_zero;
  logic                    syn_in_range;
  logic                    do_fix;
  logic [DATA_WIDTH-1:0]   corr_data;
  logic [ECC_WIDTH-1:0]    corr_ecc;

  logic [ADDR_WIDTH-1:0]   s2_addr;
  logic [ECC_WIDTH-1:0]    s2_syn;
  logic                    sec_evt;
  logic                    ded_evt;

  rvecc_syndrome #(.DATA_WIDTH(DATA_WIDTH)) u_syndrome (
    .data   (in_data),
    .ecc    (in_ecc),
    .syn    (syn_c),
    .parity (par_c)
  );

  // Stage 1: capture the raw word with its syndrome; detect-only mode masks parity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_syn     <= '0;
      s1_par     <= 1'b0;
      s1_data    <= '0;
      s1_ecc     <= '0;
      s1_addr    <= '0;
      s1_sed_ded <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_syn     <= syn_c;
        s1_par     <= par_c & ~sed_ded;
        s1_data    <= in_data;
        s1_ecc     <= in_ecc;
        s1_addr    <= in_addr;
        s1_sed_ded <= sed_ded;
      end
    end
  end

  assign syn_zero     = (s1_syn == '0);
  assign syn_in_range = (int'(s1_syn) <= NBITS);

  // Classify the stage-1 syndrome; a position beyond the codeword is never correctable.
  always_comb begin
    status = ECC_OK;
    if (s1_sed_ded || !s1_par) begin
      status = syn_zero ? ECC_OK : ECC_DED;
    end else if (syn_zero || syn_in_range) begin
      status = ECC_SEC;
    end else begin
      status = ECC_DED;
    end
  end

  assign do_fix = (status == ECC_SEC);

  for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_dfix
    localparam int POS = data_pos(DATA_WIDTH, j);
    assign corr_data[j] = s1_data[j] ^ (do_fix && int'(s1_syn) == POS);
  end

  for (genvar i = 0; i < K; i++) begin : g_efix
    assign corr_ecc[i] = s1_ecc[i] ^ (do_fix && int'(s1_syn) == (1 << i));
  end

  assign corr_ecc[K] = s1_ecc[K] ^ (do_fix && syn_zero);

  // Stage 2: register the corrected word, flags and the context kept for logging.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sec   <= 1'b0;
      out_ded   <= 1'b0;
      out_data  <= '0;
      out_ecc   <= '0;
      s2_addr   <= '0;
      s2_syn    <= '0;
    end else begin
      out_valid <= s1_valid;
      out_sec   <= s1_valid && (status == ECC_SEC);
      out_ded   <= s1_valid && (status == ECC_DED);
      if (s1_valid) begin
        out_data <= corr_data;
        out_ecc  <= corr_ecc;
        s2_addr  <= s1_addr;
        s2_syn   <= {s1_par, s1_syn};
      end
    end
  end

  assign sec_evt = out_valid & out_sec;
  assign ded_evt = out_valid & out_ded;

  function automatic logic [CNT_WIDTH-1:0] cnt_next(
    input logic [CNT_WIDTH-1:0] cur,
    input logic                 evt,
    input logic                 clr
  );
    if (clr) return evt ? CNT_WIDTH'(1) : '0;
    if (evt && cur != '1) return cur + CNT_WIDTH'(1);
    return cur;
  endfunction

  // Saturating error counters; a clear coinciding with an event keeps that event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_count <= '0;
      ded_count <= '0;
    end else begin
      sec_count <= cnt_next(sec_count, sec_evt, cnt_clear);
      ded_count <= cnt_next(ded_count, ded_evt, cnt_clear);
    end
  end

  // First-error log: DED may replace a held SEC, a held DED waits for log_clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      log_valid    <= 1'b0;
      log_ded      <= 1'b0;
      log_addr     <= '0;
      log_syndrome <= '0;
    end else if ((sec_evt || ded_evt) &&
                 (!log_valid || log_clear || (ded_evt && !log_ded))) begin
      log_valid    <= 1'b1;
      log_ded      <= ded_evt;
      log_addr     <= s2_addr;
      log_syndrome <= s2_syn;
    end else if (log_clear) begin
      log_valid <= 1'b0;
      log_ded   <= 1'b0;
    end
  end

endmodule
